// File: rtl/traffic_input_conditioner.sv
// traffic_input_conditioner
//
// Input front end for the traffic light controller. Every raw controller
// input passes through here: the two active-low crosswalk buttons and the
// three street sensors are synchronized and debounced, button presses are
// turned into one-cycle pulses and held in sticky requests until the
// controller clears them, and a single-cycle state-machine tick is produced
// every TICK_DIV cycles.
//
// Parameters
//   TICK_DIV         sysclk cycles per tick period (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced level
//                    changes (>= 1)
//
// Ports
//   sysclk, rst_n                 clock, async active-low reset
//   btn_cr_n, btn_mn_n            raw crosswalk buttons (active-low, async)
//   straight_cr_raw, turn_cr_raw,
//   turn_mn_raw                   raw street sensors (active-high, async)
//   req_clr_cr, req_clr_mn        controller clears the matching request
//   tick                          one-cycle pulse every TICK_DIV cycles
//   straight_cr, turn_cr, turn_mn debounced sensor levels
//   btn_cr_press, btn_mn_press    one-cycle pulse on a debounced press
//   btn_cr_req, btn_mn_req        sticky pending crosswalk request
//
// All outputs are registered.

module traffic_input_conditioner #(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic btn_cr_n,
  input  logic btn_mn_n,
  input  logic straight_cr_raw,
  input  logic turn_cr_raw,
  input  logic turn_mn_raw,
  input  logic req_clr_cr,
  input  logic req_clr_mn,
  output logic tick,
  output logic straight_cr,
  output logic turn_cr,
  output logic turn_mn,
  output logic btn_cr_press,
  output logic btn_mn_press,
  output logic btn_cr_req,
  output logic btn_mn_req
);

  // Channel map: 0 btn_cr, 1 btn_mn, 2 straight_cr, 3 turn_cr, 4 turn_mn.
  localparam int NCH = 5;

  // A one-cycle debounce needs no counting; keep at least one counter bit so
  // the vector stays legal.
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);

  // Buttons idle high (released), sensors idle low.
  localparam logic [NCH-1:0]    IDLE      = 5'b00011;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   deb;
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   expire;

  logic cr_fall;
  logic mn_fall;
  logic cr_press_q;
  logic mn_press_q;
  logic cr_req_q;
  logic mn_req_q;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick_q;

  assign raw = {turn_mn_raw, turn_cr_raw, straight_cr_raw, btn_mn_n, btn_cr_n};

  // A channel expires when its synchronized input has disagreed with the
  // debounced level for the full window; deb takes the new level this edge.
  always_comb begin
    // NOTE: assign every always_comb output a default before any branch or
    // loop, otherwise an unassigned path infers a latch.
    expire = '0;
    for (int i = 0; i < NCH; i++) begin
      expire[i] = (sync2[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // A press is the debounced button level falling 1->0 on this edge, so the
  // pulse and the request set land on the same edge as the deb change.
  assign cr_fall = expire[0] && deb[0];
  assign mn_fall = expire[1] && deb[1];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      deb   <= IDLE;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; sync2 <= sync1 relies on that ordering.
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == deb[i]) begin
          // Any return to the current level restarts the window.
          cnt[i] <= '0;
        end else if (expire[i]) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press pulses and sticky requests. A press on the same edge as a clear
  // wins, so a request is never lost to a clear held high by the controller.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cr_press_q <= 1'b0;
      mn_press_q <= 1'b0;
      cr_req_q   <= 1'b0;
      mn_req_q   <= 1'b0;
    end else begin
      cr_press_q <= cr_fall;
      mn_press_q <= mn_fall;

      if (cr_fall) begin
        cr_req_q <= 1'b1;
      end else if (req_clr_cr) begin
        cr_req_q <= 1'b0;
      end

      if (mn_fall) begin
        mn_req_q <= 1'b1;
      end else if (req_clr_mn) begin
        mn_req_q <= 1'b0;
      end
    end
  end

  // Free-running tick divider; the pulse is registered off the wrap so it is
  // high for the cycle after the counter returns to 0.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      tick_q   <= (tick_cnt == TICK_LAST);
    end
  end

  assign tick         = tick_q;
  assign straight_cr  = deb[2];
  assign turn_cr      = deb[3];
  assign turn_mn      = deb[4];
  assign btn_cr_press = cr_press_q;
  assign btn_mn_press = mn_press_q;
  assign btn_cr_req   = cr_req_q;
  assign btn_mn_req   = mn_req_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb_traffic_input_conditioner
//
// Directed bench for traffic_input_conditioner with TICK_DIV=10 and
// DEBOUNCE_CYCLES=4. Inputs are driven 1 time unit after a rising edge and
// outputs are sampled at the same point, so a table row's inputs are seen by
// the next edge and its expected outputs describe the state after that edge.

module tb_traffic_input_conditioner;

  localparam int TICK_DIV        = 10;
  localparam int DEBOUNCE_CYCLES = 4;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic btn_cr_n        = 1'b1;
  logic btn_mn_n        = 1'b1;
  logic straight_cr_raw = 1'b0;
  logic turn_cr_raw     = 1'b0;
  logic turn_mn_raw     = 1'b0;
  logic req_clr_cr      = 1'b0;
  logic req_clr_mn      = 1'b0;
  logic tick;
  logic straight_cr;
  logic turn_cr;
  logic turn_mn;
  logic btn_cr_press;
  logic btn_mn_press;
  logic btn_cr_req;
  logic btn_mn_req;

  traffic_input_conditioner #(
    .TICK_DIV        (TICK_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .sysclk          (sysclk),
    .rst_n           (rst_n),
    .btn_cr_n        (btn_cr_n),
    .btn_mn_n        (btn_mn_n),
    .straight_cr_raw (straight_cr_raw),
    .turn_cr_raw     (turn_cr_raw),
    .turn_mn_raw     (turn_mn_raw),
    .req_clr_cr      (req_clr_cr),
    .req_clr_mn      (req_clr_mn),
    .tick            (tick),
    .straight_cr     (straight_cr),
    .turn_cr         (turn_cr),
    .turn_mn         (turn_mn),
    .btn_cr_press    (btn_cr_press),
    .btn_mn_press    (btn_mn_press),
    .btn_cr_req      (btn_cr_req),
    .btn_mn_req      (btn_mn_req)
  );

  always #5 sysclk = ~sysclk;

  // Row inputs:  [6] btn_cr_n [5] btn_mn_n [4] straight [3] turn_cr
  //              [2] turn_mn [1] req_clr_cr [0] req_clr_mn
  // Row outputs: [6] straight_cr [5] turn_cr [4] turn_mn [3] btn_cr_press
  //              [2] btn_mn_press [1] btn_cr_req [0] btn_mn_req
  typedef struct {
    string      tag;
    logic [6:0] in;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] IN_IDLE = 7'b1100000;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edges   = 0;
  int   presses = 0;

  function automatic logic [7:0] out_all();
    return {tick, straight_cr, turn_cr, turn_mn,
            btn_cr_press, btn_mn_press, btn_cr_req, btn_mn_req};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)",
               name, act, exp, edges, $time);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
    edges++;
  endtask

  task automatic apply(input logic [6:0] in);
    {btn_cr_n, btn_mn_n, straight_cr_raw, turn_cr_raw, turn_mn_raw,
     req_clr_cr, req_clr_mn} = in;
  endtask

  task automatic add(input string tag, input logic [6:0] in,
                     input logic [6:0] exp, input int n);
    vec_t v;
    v.tag = tag;
    v.in  = in;
    v.exp = exp;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- Table: clean press + straight sensor, clear, release -------------
    add("press_wait",  7'b0110000, 7'b0000000, 5);
    add("press_edge",  7'b0110000, 7'b1001010, 1);
    add("press_hold",  7'b0110000, 7'b1000010, 2);
    add("clr_cr",      7'b0110010, 7'b1000000, 1);
    add("after_clr",   7'b0110000, 7'b1000000, 1);
    add("release",     IN_IDLE,    7'b1000000, 5);
    add("released",    IN_IDLE,    7'b0000000, 2);
    // ---- Glitch rejection: 3-cycle pulses never reach the outputs ---------
    add("glitch",      7'b1001000, 7'b0000000, 3);
    add("glitch_end",  IN_IDLE,    7'b0000000, 6);
    // ---- 4-cycle sensor pulse is exactly long enough to pass ---------------
    add("tm_pulse",    7'b1100100, 7'b0000000, 4);
    add("tm_wait",     IN_IDLE,    7'b0000000, 1);
    add("tm_high",     IN_IDLE,    7'b0010000, 4);
    add("tm_low",      IN_IDLE,    7'b0000000, 2);
    // ---- Set/clear collision with clr held high ----------------------------
    add("coll_wait",   7'b1000001, 7'b0000000, 5);
    add("coll_set",    7'b1000001, 7'b0000101, 1);
    add("coll_clr",    7'b1000001, 7'b0000000, 1);
    add("coll_hold",   7'b1000000, 7'b0000000, 1);
    add("coll_rel",    IN_IDLE,    7'b0000000, 6);

    // ---- 1. Reset and tick -------------------------------------------------
    #3;
    check("rst_outputs_t0", out_all(), 8'h00);
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_outputs_held", out_all(), 8'h00);
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      check($sformatf("tick_e%0d", edges), tick,
            (edges == 10 || edges == 20 || edges == 30));
    end

    // ---- 2-4. Table-driven vectors -----------------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].in);
      step();
      check($sformatf("%s[%0d]", vecs[i].tag, i), out_all() & 8'h7f,
            {1'b0, vecs[i].exp});
    end
    apply(IN_IDLE);

    // ---- 5. Release bounce -------------------------------------------------
    presses  = 0;
    btn_cr_n = 1'b0;
    repeat (8) begin
      step();
      if (btn_cr_press) presses++;
    end
    check("bounce_req_set", btn_cr_req, 1);
    for (int seg = 0; seg < 4; seg++) begin
      btn_cr_n = (seg % 2 == 0);
      repeat (2) begin
        step();
        if (btn_cr_press) presses++;
      end
    end
    btn_cr_n = 1'b1;  // final rise, seen by edge f = step 1 below
    for (int i = 1; i <= 8; i++) begin
      step();
      if (btn_cr_press) presses++;
      if (i == 5) check("bounce_deb_low_f4",  dut.deb[0], 0);
      if (i == 6) check("bounce_deb_high_f5", dut.deb[0], 1);
    end
    check("bounce_press_count", presses, 1);
    req_clr_cr = 1'b1;
    step();
    check("bounce_clr", btn_cr_req, 0);
    req_clr_cr = 1'b0;

    // ---- 6. Reset mid-operation --------------------------------------------
    btn_mn_n = 1'b0;
    repeat (6) step();
    check("mid_req_set", btn_mn_req, 1);
    for (int i = 0; i < 10; i++) begin
      if ((edges % 10) == 3) break;
      step();
    end
    turn_cr_raw = 1'b1;
    btn_mn_n    = 1'b1;
    repeat (4) step();
    check("mid_pre_tick_cnt", dut.tick_cnt, 7);
    check("mid_pre_deb_cnt",  dut.cnt[3], 2);
    check("mid_pre_req",      btn_mn_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", out_all(), 8'h00);
    turn_cr_raw = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("post_rst_e%0d", edges), out_all(),
            (edges == 10) ? 8'h80 : 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
